uart_fifo_ctrl: RTL and testbench
=================================

Name: uart_fifo_ctrl

Overview:
- Single-clock FIFO controller that sequences a simple-dual-port RAM (one write port, one registered read port) as the byte buffer between the UART host interface and the TX/RX shifters.
- Owns the read/write pointers, occupancy count and full/empty/almost flags, and the push/pop handshake.
- Absorbs the RAM's one-cycle registered-read latency, so the consumer sees a qualified data strobe.
- Both RAM clocks are tied to this block's clock at the instantiation.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry (matches the RAM data width)
ADDR_WIDTH, 3, RAM address width; depth = 2**ADDR_WIDTH
AFULL_LEVEL, 6, occupancy at or above which almost_full asserts (1 .. 2**ADDR_WIDTH)

Ports:
clock  input  1  single clock; also drives the RAM read and write clocks
reset_n  input  1  synchronous active-low reset; one clock, sampled on posedge clock
push  input  1  write request; wr_data is sampled this cycle
wr_data  input  DATA_WIDTH  entry to enqueue
pop  input  1  read request
rd_data  output  DATA_WIDTH  dequeued entry; valid only when rd_valid=1
rd_valid  output  1  one-cycle strobe; rd_data holds the entry popped in the previous cycle
full  output  1  occupancy == 2**ADDR_WIDTH
empty  output  1  occupancy == 0
almost_full  output  1  occupancy >= AFULL_LEVEL
level  output  ADDR_WIDTH+1  current occupancy, 0 .. 2**ADDR_WIDTH
overflow  output  1  sticky; push rejected while full
underflow  output  1  sticky; pop rejected while empty
clear  input  1  synchronous flush; pointers, level and sticky flags return to reset values
ram_we  output  1  RAM write enable
ram_write_addr  output  ADDR_WIDTH  RAM write address
ram_data  output  DATA_WIDTH  RAM write data
ram_read_addr  output  ADDR_WIDTH  RAM read address
ram_q  input  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset (reset_n=0 at a posedge):
  - wr_ptr=rd_ptr=0, where both pointers are ADDR_WIDTH+1 bits with an extra wrap bit.
  - level=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0.
  - reset_n takes priority over clear, push and pop.
- clear=1 has the same effect as reset but does not depend on reset_n. A push or pop in the same cycle as clear is discarded.
- Accept rules, evaluated on registered state at the start of the cycle:
  - push_ok = push & (~full | pop_ok)
  - pop_ok = pop & ~empty
  - When full, a push is accepted only together with a pop.
  - When empty, a simultaneous push is accepted and the pop is rejected; there is no fall-through.
- RAM drive, all combinational:
  - ram_we = push_ok
  - ram_write_addr = wr_ptr[ADDR_WIDTH-1:0]
  - ram_data = wr_data
  - ram_read_addr = rd_ptr[ADDR_WIDTH-1:0]
- Pointer updates:
  - wr_ptr increments by 1 on push_ok; rd_ptr increments by 1 on pop_ok.
  - Both pointers wrap modulo 2**(ADDR_WIDTH+1).
- level next value:
  - level+1 on push_ok only; level-1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (lower bits equal) & (wrap bits differ).
  - Both flags are registered or decoded from registered pointers, with no combinational path from push/pop.
- Read latency:
  - A pop_ok in cycle N makes the RAM register the entry at the edge ending cycle N.
  - rd_valid=1 during cycle N+1 only; rd_data = ram_q passes through.
  - Back-to-back pops give one entry per cycle.
- Full with push and pop together: the read and write addresses are equal. The RAM returns the old (oldest) entry, because the read is registered before the write takes effect. rd_data is correct and level stays at 2**ADDR_WIDTH.
- Rejected push while full: RAM is not written, state is unchanged, overflow sets and holds until reset or clear.
- Rejected pop while empty: rd_valid stays 0, underflow sets and holds.
- Reset or clear in the cycle after a pop_ok: rd_valid is forced to 0 in the following cycle.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop 3 times back-to-back -> rd_valid high for 3 cycles starting one cycle after the first pop; rd_data 0x11,0x22,0x33; level 0→3→0; empty returns to 1.
- Push 8 entries 0xA0..0xA7 with defaults -> full=1 at level 8; almost_full first asserts at level 6. A 9th push leaves level at 8 and sets overflow=1. Popping all 8 returns 0xA0..0xA7 in order.
- Fill to 8, then push 0xB0 and pop in the same cycle -> level stays 8, rd_data=0xA0 next cycle, and 0xB0 is the last entry returned after draining.
- Pop while empty, and separately push 0x5A+pop while empty -> underflow=1 with no rd_valid. In the second case 0x5A is stored (level=1) and no data is returned that cycle.
- Cycle 20 pushes through the FIFO, keeping 1–3 entries in flight -> pointers wrap past address 7 with no data loss or reordering.
- Assert reset_n=0 for one cycle while level=5 with a pop pending, and repeat with clear=1 -> next cycle level=0, empty=1, rd_valid=0, flags cleared.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
//
// Purpose:
//   Single-clock FIFO controller sitting between the UART host interface and
//   the TX/RX shifters. It owns the read/write pointers, the occupancy count,
//   the status flags and the push/pop handshake, and drives an external
//   simple-dual-port RAM (one write port, one registered read port) whose
//   clocks are tied to `clock` at the instantiation. The RAM's one-cycle read
//   latency is absorbed here, so the consumer sees a qualified data strobe.
//
// Ports:
//   clock           single clock (also the RAM read/write clock)
//   reset_n         synchronous active-low reset
//   push, wr_data   enqueue request and the entry to store
//   pop             dequeue request
//   rd_data         dequeued entry, meaningful only while rd_valid=1
//   rd_valid        one-cycle strobe, the cycle after an accepted pop
//   full, empty     occupancy == depth / occupancy == 0
//   almost_full     occupancy >= AFULL_LEVEL
//   level           current occupancy, 0 .. depth
//   overflow        sticky: a push was rejected while full
//   underflow       sticky: a pop was rejected while empty
//   clear           synchronous flush, same effect as reset
//   ram_we, ram_write_addr, ram_data   RAM write port
//   ram_read_addr, ram_q               RAM registered read port
module uart_fifo_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 3,
   parameter int AFULL_LEVEL = 6
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clear,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the address bits match.
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic [ADDR_WIDTH:0] level_q;
   logic                overflow_q;
   logic                underflow_q;
   logic                rd_valid_q;

   logic flush;
   logic push_ok;
   logic pop_ok;

   // Reset and clear share one flush path; any push or pop in a flush cycle
   // is discarded, including the RAM write.
   assign flush = ~reset_n | clear;

   // Flags decode only registered pointers: no combinational path from
   // push/pop to full/empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

   // A push into a full FIFO is allowed only with a simultaneous pop; read
   // and write addresses are then equal and the registered read returns the
   // old entry before the write lands. No fall-through when empty.
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & (~full | pop_ok) & ~flush;

   assign ram_we         = push_ok;
   assign ram_write_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_data       = wr_data;
   assign ram_read_addr  = rd_ptr[ADDR_WIDTH-1:0];

   assign rd_data     = ram_q;
   assign rd_valid    = rd_valid_q;
   assign level       = level_q;
   assign almost_full = (level_q >= AFULL_LVL);
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + PTR_ONE;
            2'b01:   level_q <= level_q - PTR_ONE;
            default: level_q <= level_q;
         endcase
         overflow_q  <= overflow_q | (push & ~push_ok);
         underflow_q <= underflow_q | (pop & empty);
         // The RAM registers the popped entry at this edge, so the strobe
         // lines up with ram_q in the next cycle.
         rd_valid_q  <= pop_ok;
      end
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          push;
   logic [DW-1:0] wr_data;
   logic          pop;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic [AW:0]   level;
   logic          overflow;
   logic          underflow;
   logic          clear;
   logic          ram_we;
   logic [AW-1:0] ram_write_addr;
   logic [DW-1:0] ram_data;
   logic [AW-1:0] ram_read_addr;
   logic [DW-1:0] ram_q;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   // Simple-dual-port RAM with registered read (read-before-write).
   always @(posedge clock) begin
      if (ram_we) mem[ram_write_addr] <= ram_data;
      ram_q <= mem[ram_read_addr];
   end

   uart_fifo_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AFULL_LEVEL(6)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .push(push),
      .wr_data(wr_data),
      .pop(pop),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .level(level),
      .overflow(overflow),
      .underflow(underflow),
      .clear(clear),
      .ram_we(ram_we),
      .ram_write_addr(ram_write_addr),
      .ram_data(ram_data),
      .ram_read_addr(ram_read_addr),
      .ram_q(ram_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q,
                      input logic c, input logic r);
      push = p; wr_data = d; pop = q; clear = c; reset_n = r;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      push = 1'b0; wr_data = '0; pop = 1'b0; clear = 1'b0; reset_n = 1'b0;

      // reset, with a push attempted during reset
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);
      chk("rst_rdv", 32'(rd_valid), 32'd0);

      // push 11,22,33 then pop three back-to-back
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
      chk("t1_lvl1", 32'(level), 32'd1);
      chk("t1_notempty", 32'(empty), 32'd0);
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
      chk("t1_lvl2", 32'(level), 32'd2);
      cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
      chk("t1_lvl3", 32'(level), 32'd3);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("t1_rdv0", 32'(rd_valid), 32'd1);
      chk("t1_rd0", 32'(rd_data), 32'h11);
      chk("t1_lvlp1", 32'(level), 32'd2);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("t1_rdv1", 32'(rd_valid), 32'd1);
      chk("t1_rd1", 32'(rd_data), 32'h22);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("t1_rdv2", 32'(rd_valid), 32'd1);
      chk("t1_rd2", 32'(rd_data), 32'h33);
      chk("t1_lvl0", 32'(level), 32'd0);
      idle();
      chk("t1_rdv_end", 32'(rd_valid), 32'd0);
      chk("t1_empty", 32'(empty), 32'd1);

      // fill with A0..A7: almost_full from level 6, full at 8
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
         chk("t2_lvl", 32'(level), 32'(i + 1));
         chk("t2_afull", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
         chk("t2_full", 32'(full), (i + 1 == 8) ? 32'd1 : 32'd0);
      end
      push = 1'b1; wr_data = 8'hA8; pop = 1'b0;
      #1;
      chk("t2_we_blocked", 32'(ram_we), 32'd0);
      cyc(1'b1, 8'hA8, 1'b0, 1'b0, 1'b1);
      chk("t2_lvl_ovf", 32'(level), 32'd8);
      chk("t2_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
         chk("t2_rdv", 32'(rd_valid), 32'd1);
         chk("t2_rd", 32'(rd_data), 32'hA0 + 32'(i));
      end
      chk("t2_empty", 32'(empty), 32'd1);
      chk("t2_ovf_sticky", 32'(overflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("t2_clr_ovf", 32'(overflow), 32'd0);

      // full with push+pop together
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
      chk("t3_full", 32'(full), 32'd1);
      cyc(1'b1, 8'hB0, 1'b1, 1'b0, 1'b1);
      chk("t3_lvl", 32'(level), 32'd8);
      chk("t3_rdv", 32'(rd_valid), 32'd1);
      chk("t3_rd", 32'(rd_data), 32'hA0);
      chk("t3_noovf", 32'(overflow), 32'd0);
      for (int i = 1; i < 9; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
         chk("t3_drain", 32'(rd_data), (i == 8) ? 32'hB0 : 32'hA0 + 32'(i));
      end
      chk("t3_empty", 32'(empty), 32'd1);

      // pop while empty; then push+pop while empty
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("t4_rdv", 32'(rd_valid), 32'd0);
      chk("t4_udf", 32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("t4_clr_udf", 32'(underflow), 32'd0);
      cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
      chk("t4b_lvl", 32'(level), 32'd1);
      chk("t4b_rdv", 32'(rd_valid), 32'd0);
      chk("t4b_udf", 32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("t4b_rdv2", 32'(rd_valid), 32'd1);
      chk("t4b_rd", 32'(rd_data), 32'h5A);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // stream 20 entries, two in flight, pointers wrap
      begin
         int npop = 0;
         for (int i = 0; i < 22; i++) begin
            cyc((i < 20) ? 1'b1 : 1'b0, 8'hC0 + 8'(i), (i >= 2) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            if (i >= 2) begin
               chk("t5_rdv", 32'(rd_valid), 32'd1);
               chk("t5_rd", 32'(rd_data), 32'hC0 + 32'(npop));
               npop++;
            end
            if (i >= 1 && i < 20) chk("t5_lvl", 32'(level), 32'd2);
         end
         chk("t5_count", 32'(npop), 32'd20);
      end
      chk("t5_empty", 32'(empty), 32'd1);

      // reset with a pop pending at level 5, sticky flag set beforehand
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b1);
      chk("t6_lvl5", 32'(level), 32'd5);
      chk("t6_udf_set", 32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t6_rst_lvl", 32'(level), 32'd0);
      chk("t6_rst_empty", 32'(empty), 32'd1);
      chk("t6_rst_rdv", 32'(rd_valid), 32'd0);
      chk("t6_rst_udf", 32'(underflow), 32'd0);

      // same with clear
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b1);
      chk("t6c_lvl5", 32'(level), 32'd5);
      cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
      chk("t6c_lvl", 32'(level), 32'd0);
      chk("t6c_empty", 32'(empty), 32'd1);
      chk("t6c_rdv", 32'(rd_valid), 32'd0);
      chk("t6c_udf", 32'(underflow), 32'd0);
      chk("t6c_afull", 32'(almost_full), 32'd0);
      idle();
      chk("t6c_stay_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
